// File: rtl/address_to_index.sv
//==============================================================================
// Module      : address_to_index
// Description : Sequential inverse of the coprocessor index-to-address map.
//               Decodes a memory address into the matrix it belongs to
//               (A, B or output), the block row/column and the element offset
//               inside the k*k block. The block row/column split uses iterative
//               subtraction rather than a divider.
// Ports       : i_Clk, i_Reset_n      clock (rising edge), async active-low reset
//               i_Config [31:0]       [23:16]=mu, [15:8]=gamma, [7:0]=lambda
//               i_Start, i_Address    request, sampled only when idle
//               o_Busy                high from the cycle after acceptance until DONE exits
//               o_Done                one-cycle pulse, results valid
//               o_Type                001=A, 010=B, 100=output, 000=invalid
//               o_Row_Index, o_Column_Index, o_Element   decoded position
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module address_to_index #(
    parameter int INDEX_WIDTH     = 8,
    parameter int K               = 2,
    parameter int LOG_MEMORY_SIZE = 10,
    parameter int OUTPUT_START    = 700,
    localparam int KK_LOG         = $clog2(K * K),
    localparam int EW             = (KK_LOG < 1) ? 1 : KK_LOG
) (
    input  wire logic                       i_Clk,
    input  wire logic                       i_Reset_n,
    input  wire logic [31:0]                i_Config,
    input  wire logic                       i_Start,
    input  wire logic [LOG_MEMORY_SIZE-1:0] i_Address,
    output logic                            o_Busy,
    output logic                            o_Done,
    output logic [2:0]                      o_Type,
    output logic [INDEX_WIDTH-1:0]          o_Row_Index,
    output logic [INDEX_WIDTH-1:0]          o_Column_Index,
    output logic [EW-1:0]                   o_Element
);

    localparam int c_KK = K * K;
    // Wide enough for the largest region product (8b * 8b * KK) and for the
    // end-of-region sums, so nothing wraps.
    localparam int c_PW = 16 + KK_LOG;
    localparam int CW   = ((LOG_MEMORY_SIZE > c_PW) ? LOG_MEMORY_SIZE : c_PW) + 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_DIVIDE   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                     r_state;
    logic [LOG_MEMORY_SIZE-1:0] r_addr;
    logic [23:0]                r_config;
    logic [LOG_MEMORY_SIZE-1:0] r_rem;
    logic [7:0]                 r_width;
    logic [INDEX_WIDTH-1:0]     r_row_cnt;
    logic [2:0]                 r_type_work;
    logic [EW-1:0]              r_elem_work;
    logic                       r_busy;
    logic                       r_done;
    logic [2:0]                 r_type;
    logic [INDEX_WIDTH-1:0]     r_row;
    logic [INDEX_WIDTH-1:0]     r_col;
    logic [EW-1:0]              r_elem;

    logic [CW-1:0]              w_mu, w_gamma, w_lambda;
    logic [CW-1:0]              w_size_a, w_size_b, w_size_o;
    logic [CW-1:0]              w_base_b, w_addr, w_base, w_off;
    logic                       w_hit_a, w_hit_b, w_hit_o;
    logic                       w_valid;
    logic [2:0]                 w_type;
    logic [7:0]                 w_width;
    logic [EW-1:0]              w_elem;
    logic [LOG_MEMORY_SIZE-1:0] w_rem;
    logic                       w_unused_cfg;

    assign w_unused_cfg = ^i_Config[31:24];

    // Region classification from the captured request. Empty regions can
    // never hit because [base, base+0) contains no address.
    always_comb begin
        w_mu     = CW'(r_config[23:16]);
        w_gamma  = CW'(r_config[15:8]);
        w_lambda = CW'(r_config[7:0]);
        w_size_a = (w_lambda * w_mu) << KK_LOG;
        w_size_b = (w_mu * w_gamma) << KK_LOG;
        w_size_o = (w_lambda * w_gamma) << KK_LOG;
        w_base_b = CW'(2) + w_size_a;
        w_addr   = CW'(r_addr);

        w_hit_o = (w_addr >= CW'(OUTPUT_START)) && (w_addr < CW'(OUTPUT_START) + w_size_o);
        w_hit_a = (w_addr >= CW'(2)) && (w_addr < w_base_b);
        w_hit_b = (w_addr >= w_base_b) && (w_addr < w_base_b + w_size_b);

        w_valid = 1'b0;
        w_type  = 3'b000;
        w_base  = '0;
        w_width = 8'd0;
        if (w_hit_o) begin
            w_valid = 1'b1;
            w_type  = 3'b100;
            w_base  = CW'(OUTPUT_START);
            w_width = r_config[15:8];
        end else if (w_hit_a) begin
            w_valid = 1'b1;
            w_type  = 3'b001;
            w_base  = CW'(2);
            w_width = r_config[23:16];
        end else if (w_hit_b) begin
            w_valid = 1'b1;
            w_type  = 3'b010;
            w_base  = w_base_b;
            w_width = r_config[15:8];
        end

        // KK is a power of two: low bits are the element, the rest is the
        // linear block number that DIVIDE splits into row/column.
        w_off  = w_addr - w_base;
        w_elem = EW'(w_off & CW'(c_KK - 1));
        w_rem  = LOG_MEMORY_SIZE'(w_off >> KK_LOG);
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_config    <= '0;
            r_rem       <= '0;
            r_width     <= '0;
            r_row_cnt   <= '0;
            r_type_work <= '0;
            r_elem_work <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_type      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_elem      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_Start) begin
                        r_addr   <= i_Address;
                        r_config <= i_Config[23:0];
                        r_busy   <= 1'b1;
                        r_state  <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    if (w_valid) begin
                        r_type_work <= w_type;
                        r_elem_work <= w_elem;
                        r_rem       <= w_rem;
                        r_width     <= w_width;
                        r_row_cnt   <= '0;
                        r_state     <= ST_DIVIDE;
                    end else begin
                        r_type  <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_elem  <= '0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DIVIDE: begin
                    if (CW'(r_rem) >= CW'(r_width)) begin
                        r_rem     <= r_rem - LOG_MEMORY_SIZE'(r_width);
                        r_row_cnt <= r_row_cnt + INDEX_WIDTH'(1);
                    end else begin
                        // Visible outputs change only here, never mid-divide.
                        r_type  <= r_type_work;
                        r_row   <= r_row_cnt;
                        r_col   <= INDEX_WIDTH'(r_rem);
                        r_elem  <= r_elem_work;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_Busy         = r_busy;
    assign o_Done         = r_done;
    assign o_Type         = r_type;
    assign o_Row_Index    = r_row;
    assign o_Column_Index = r_col;
    assign o_Element      = r_elem;

endmodule

`default_nettype wire

// File: tb/tb_address_to_index.sv
//==============================================================================
// Module      : tb_address_to_index
// Description : Directed self-checking bench for address_to_index, including
//               an exhaustive sweep against a forward index-to-address model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_address_to_index;

    localparam int c_LIMIT = 400;

    logic        i_Clk;
    logic        i_Reset_n;
    logic [31:0] i_Config;
    logic        i_Start;
    logic [9:0]  i_Address;
    logic        o_Busy;
    logic        o_Done;
    logic [2:0]  o_Type;
    logic [7:0]  o_Row_Index;
    logic [7:0]  o_Column_Index;
    logic [1:0]  o_Element;

    int checks;
    int errors;

    int exp_type [0:1023];
    int exp_row  [0:1023];
    int exp_col  [0:1023];
    int exp_elem [0:1023];

    address_to_index dut (
        .i_Clk          (i_Clk),
        .i_Reset_n      (i_Reset_n),
        .i_Config       (i_Config),
        .i_Start        (i_Start),
        .i_Address      (i_Address),
        .o_Busy         (o_Busy),
        .o_Done         (o_Done),
        .o_Type         (o_Type),
        .o_Row_Index    (o_Row_Index),
        .o_Column_Index (o_Column_Index),
        .o_Element      (o_Element)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Forward map: every (matrix,row,col,elem) placed at its address. Filled
    // lowest priority first so higher-priority regions overwrite on overlap.
    task automatic build_model(input int mu, input int gamma, input int lambda);
        int a;
        for (int i = 0; i < 1024; i++) begin
            exp_type[i] = 0; exp_row[i] = 0; exp_col[i] = 0; exp_elem[i] = 0;
        end
        for (int r = 0; r < mu; r++)
            for (int c = 0; c < gamma; c++)
                for (int e = 0; e < 4; e++) begin
                    a = 2 + lambda*mu*4 + (r*gamma + c)*4 + e;
                    if (a < 1024) begin
                        exp_type[a] = 2; exp_row[a] = r; exp_col[a] = c; exp_elem[a] = e;
                    end
                end
        for (int r = 0; r < lambda; r++)
            for (int c = 0; c < mu; c++)
                for (int e = 0; e < 4; e++) begin
                    a = 2 + (r*mu + c)*4 + e;
                    if (a < 1024) begin
                        exp_type[a] = 1; exp_row[a] = r; exp_col[a] = c; exp_elem[a] = e;
                    end
                end
        for (int r = 0; r < lambda; r++)
            for (int c = 0; c < gamma; c++)
                for (int e = 0; e < 4; e++) begin
                    a = 700 + (r*gamma + c)*4 + e;
                    if (a < 1024) begin
                        exp_type[a] = 4; exp_row[a] = r; exp_col[a] = c; exp_elem[a] = e;
                    end
                end
    endtask

    // One request; checks latency, pulse width, busy window and all fields.
    task automatic run(input string tag, input int addr, input int etype,
                       input int erow, input int ecol, input int eelem, input int ecyc);
        int cyc;
        @(negedge i_Clk);
        i_Address = 10'(addr);
        i_Start   = 1'b1;
        @(posedge i_Clk);
        #1;
        i_Start = 1'b0;
        cyc = 1;
        check({tag, " busy_c1"}, int'(o_Busy), 1);
        while (!o_Done && cyc < c_LIMIT) begin
            @(posedge i_Clk);
            #1;
            cyc++;
        end
        check({tag, " done_seen"}, int'(o_Done), 1);
        check({tag, " done_cycle"}, cyc, ecyc);
        check({tag, " busy_at_done"}, int'(o_Busy), 1);
        check({tag, " type"}, int'(o_Type), etype);
        check({tag, " row"}, int'(o_Row_Index), erow);
        check({tag, " col"}, int'(o_Column_Index), ecol);
        check({tag, " elem"}, int'(o_Element), eelem);
        @(posedge i_Clk);
        #1;
        check({tag, " done_pulse"}, int'(o_Done), 0);
        check({tag, " busy_end"}, int'(o_Busy), 0);
        check({tag, " type_hold"}, int'(o_Type), etype);
    endtask

    initial begin
        int cyc;
        int seen;
        checks    = 0;
        errors    = 0;
        i_Reset_n = 1'b0;
        i_Start   = 1'b0;
        i_Address = '0;
        i_Config  = 32'h0003_0202;
        build_model(3, 2, 2);

        repeat (2) @(posedge i_Clk);
        #1;
        check("reset busy", int'(o_Busy), 0);
        check("reset done", int'(o_Done), 0);
        check("reset type", int'(o_Type), 0);
        check("reset row", int'(o_Row_Index), 0);
        check("reset col", int'(o_Column_Index), 0);
        check("reset elem", int'(o_Element), 0);
        @(negedge i_Clk);
        i_Reset_n = 1'b1;

        run("a2",   2,   1, 0, 0, 0, 3);
        run("a21",  21,  1, 1, 1, 3, 4);
        run("b45",  45,  2, 2, 0, 3, 5);
        run("o713", 713, 4, 1, 1, 1, 4);
        run("inv50", 50, 0, 0, 0, 0, 2);
        run("a25",  25,  1, 1, 2, 3, 4);
        run("b26",  26,  2, 0, 0, 0, 3);
        run("o715", 715, 4, 1, 1, 3, 4);
        run("inv0", 0,   0, 0, 0, 0, 2);
        run("inv716", 716, 0, 0, 0, 0, 2);

        // Start pulse and input changes while busy must not disturb the run.
        @(negedge i_Clk);
        i_Address = 10'd45;
        i_Start   = 1'b1;
        @(posedge i_Clk);
        #1;
        i_Start = 1'b0;
        cyc  = 1;
        seen = 0;
        @(negedge i_Clk);
        i_Address = 10'd2;
        i_Config  = 32'h0001_0101;
        i_Start   = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_Clk);
            #1;
            if (o_Done) seen++;
        end
        check("ignore done_count", seen, 1);
        check("ignore type", int'(o_Type), 2);
        check("ignore row", int'(o_Row_Index), 2);
        check("ignore col", int'(o_Column_Index), 0);
        check("ignore elem", int'(o_Element), 3);
        check("ignore busy", int'(o_Busy), 0);
        i_Config = 32'h0003_0202;

        // Reset in the middle of DIVIDE aborts the request.
        @(negedge i_Clk);
        i_Address = 10'd45;
        i_Start   = 1'b1;
        @(posedge i_Clk);
        #1;
        i_Start = 1'b0;
        @(posedge i_Clk);
        #1;
        @(posedge i_Clk);
        #1;
        i_Reset_n = 1'b0;
        #1;
        check("abort busy", int'(o_Busy), 0);
        check("abort done", int'(o_Done), 0);
        check("abort type", int'(o_Type), 0);
        check("abort row", int'(o_Row_Index), 0);
        check("abort elem", int'(o_Element), 0);
        @(negedge i_Clk);
        i_Reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_Clk);
            #1;
            if (o_Done) seen++;
        end
        check("abort no_done", seen, 0);

        // Exhaustive sweep against the forward model.
        for (int a = 0; a < 1024; a++) begin
            run($sformatf("sweep%0d", a), a, exp_type[a], exp_row[a], exp_col[a],
                exp_elem[a], (exp_type[a] != 0) ? exp_row[a] + 3 : 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
